// File: rtl/mac_acc_fixed_pe_pkg.sv
// Shared types and the fixed-point shift/round/saturate helper for the MAC PE.
package mac_pkg;

  typedef enum logic [1:0] {MAC_IDLE, MAC_ACCUM, MAC_HOLD} mac_state_e;

  localparam int unsigned SR_W = 64;

  typedef struct packed {
    logic signed [SR_W-1:0] data;
    logic                   sat;
  } sat_res_t;

  // Works on a sign-extended 64-bit view so one helper serves every ACC_W/OUT_W pairing.
  function automatic sat_res_t sat_round(input logic signed [SR_W-1:0] acc,
                                         input int unsigned            shift,
                                         input logic                   round_en,
                                         input logic                   sat_en,
                                         input int unsigned            out_w);
    logic signed [SR_W-1:0] s;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    sat_res_t               r;
    s = acc;
    if (round_en && shift != 0) s = s + (SR_W'(1) <<< (shift - 1));
    s  = s >>> shift;
    hi = (SR_W'(1) <<< (out_w - 1)) - SR_W'(1);
    lo = ~hi;
    r.sat  = (s > hi) || (s < lo);
    r.data = (r.sat && sat_en) ? ((s < lo) ? lo : hi) : s;
    return r;
  endfunction

endpackage

// File: rtl/mac_acc_fixed_pe_sat_round.sv
// Combinational accumulator-to-result conversion: shift, optional round, clip or wrap.
module mac_sat_round
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned OUT_SHIFT = 0,
  parameter bit          ROUND_EN  = 1'b1
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    sat_en,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  sat_res_t res;
  logic     unused_hi;

  always_comb begin
    res  = sat_round(SR_W'(acc), OUT_SHIFT, ROUND_EN, sat_en, OUT_W);
    data = res.data[OUT_W-1:0];
    sat  = res.sat;
  end

  // Upper bits only matter through the range check already folded into sat.
  assign unused_hi = ^res.data[SR_W-1:OUT_W];

endmodule

// File: rtl/mac_acc_fixed_pe.sv
// Signed fixed-point MAC PE: product stage, guarded accumulator stage and a
// valid/ready result register with a single global stall.
module mac_acc_fixed_pe
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_W    = 8,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned OUT_SHIFT = 0,
  parameter bit          ROUND_EN  = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     sat_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     out_ovf,
  output logic [CNT_W-1:0]         out_count
);

  if (FRAC_W >= DATA_W) begin : g_bad_frac
    $error("FRAC_W must leave at least one integer bit in DATA_W");
  end
  if (ACC_W <= 2 * DATA_W || ACC_W >= SR_W) begin : g_bad_acc
    $error("ACC_W needs guard bits above the full product and must fit the rounding helper");
  end

  logic                      en;
  logic                      accept;
  logic                      a_fire;
  logic                      p_valid;
  logic                      p_first;
  logic                      p_last;
  logic signed [2*DATA_W-1:0] p_prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic                      wrap;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          count_next;
  logic                      ovf;
  logic                      ovf_next;
  logic signed [OUT_W-1:0]   res_data;
  logic                      res_sat;
  mac_state_e                state;
  mac_state_e                state_next;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign a_fire   = p_valid & en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_prod  <= '0;
    end else if (en) begin
      p_valid <= accept;
      if (accept) begin
        p_prod  <= a * b;
        p_first <= in_first;
        p_last  <= in_last;
      end
    end
  end

  always_comb begin
    prod_ext   = ACC_W'(p_prod);
    sum        = acc + prod_ext;
    wrap       = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    acc_next   = p_first ? prod_ext : sum;
    count_next = p_first ? CNT_W'(1) : ((&count) ? count : count + 1'b1);
    ovf_next   = p_first ? 1'b0 : (ovf | wrap);
  end

  mac_sat_round #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT),
    .ROUND_EN (ROUND_EN)
  ) u_sat_round (
    .acc   (acc_next),
    .sat_en(sat_en),
    .data  (res_data),
    .sat   (res_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else begin
      if (a_fire) begin
        acc   <= acc_next;
        count <= count_next;
        ovf   <= ovf_next;
      end
      // A last arriving while the old result retires replaces it without a bubble.
      if (a_fire && p_last) begin
        out_valid <= 1'b1;
        out_data  <= res_data;
        out_sat   <= res_sat;
        out_ovf   <= ovf_next;
        out_count <= count_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MAC_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (a_fire)                               state_next = p_last ? MAC_HOLD : MAC_ACCUM;
    else if (state == MAC_HOLD && out_ready)  state_next = MAC_IDLE;
  end

  a_valid_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> state == MAC_HOLD);

endmodule

// File: tb/tb_mac_acc_fixed_pe.sv
// Bench for mac_acc_fixed_pe: directed cases plus randomized frames against an arithmetic model.
module tb_mac_acc_fixed_pe;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 40;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic sat_en = 1'b1, out_ready = 1'b1;
  logic [DATA_W-1:0] a = '0, b = '0;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [31:0] out_data0, out_data1, out_data2;
  logic        out_sat0, out_sat1, out_sat2;
  logic        out_ovf0, out_ovf1, out_ovf2;
  logic [15:0] out_count0, out_count1;
  logic [3:0]  out_count2;

  always #5 clk = ~clk;

  mac_acc_fixed_pe dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .sat_en(sat_en), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_sat(out_sat0), .out_ovf(out_ovf0), .out_count(out_count0));

  mac_acc_fixed_pe #(.OUT_SHIFT(8), .ROUND_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .sat_en(sat_en), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_sat(out_sat1), .out_ovf(out_ovf1), .out_count(out_count1));

  mac_acc_fixed_pe #(.CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .sat_en(sat_en), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sat(out_sat2), .out_ovf(out_ovf2), .out_count(out_count2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: exact integer sums, wrapped to the accumulator width by value.
  typedef struct {
    logic [31:0] d0;
    logic        s0;
    logic [31:0] d8;
    logic        s8;
    logic        ovf;
    longint      cnt;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur;
  longint m_acc = 0;
  longint m_cnt = 0;
  logic   m_ovf = 1'b0;

  function automatic longint wrap_acc(input longint v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return t;
  endfunction

  function automatic void result(input longint acc, input int shift, input logic sat,
                                 output logic [31:0] d, output logic f);
    longint s;
    longint hi;
    longint lo;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    s  = acc;
    if (shift > 0) s = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    f = (s > hi) || (s < lo);
    if (f && sat) s = (s > hi) ? hi : lo;
    d = s[31:0];
  endfunction

  function automatic void model_accept(input logic signed [15:0] av, input logic signed [15:0] bv,
                                       input logic first, input logic last, input logic sat);
    longint      p;
    longint      e;
    exp_t        x;
    logic [31:0] d0, d8;
    logic        f0, f8;
    p = longint'(av) * longint'(bv);
    if (first) begin
      m_acc = p;
      m_cnt = 1;
      m_ovf = 1'b0;
    end else begin
      e = m_acc + p;
      if (e > ACC_MAX || e < ACC_MIN) m_ovf = 1'b1;
      m_acc = wrap_acc(e);
      m_cnt++;
    end
    if (last) begin
      result(m_acc, 0, sat, d0, f0);
      result(m_acc, 8, sat, d8, f8);
      x.d0 = d0; x.s0 = f0; x.d8 = d8; x.s8 = f8; x.ovf = m_ovf; x.cnt = m_cnt;
      exp_q.push_back(x);
    end
  endfunction

  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (out_valid0 && out_ready) begin
        check_eq("result_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check_eq("data", out_data0, cur.d0);
          check_eq("sat", out_sat0, cur.s0);
          check_eq("ovf", out_ovf0, cur.ovf);
          check_eq("count", out_count0, (cur.cnt > 65535) ? 65535 : cur.cnt);
          check_eq("data_sh8", out_data1, cur.d8);
          check_eq("sat_sh8", out_sat1, cur.s8);
          check_eq("count_w4", out_count2, (cur.cnt > 15) ? 15 : cur.cnt);
          check_eq("lockstep", {out_valid1, out_valid2, in_ready1, in_ready2}, 4'hF);
          check_eq("lockstep_misc", {out_data2, out_sat2, out_ovf2, out_ovf1, out_count1},
                   {out_data0, out_sat0, out_ovf0, out_ovf0, out_count0});
        end
      end
      if (hold_prev && out_valid0) check_eq("stall_stable", out_data0, hold_data);
      hold_prev = out_valid0 && !out_ready;
      hold_data = out_data0;
      if (in_valid && in_ready0) model_accept(a, b, in_first, in_last, sat_en);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the pair was taken.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic f, input logic l);
    a = av; b = bv; in_first = f; in_last = l; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready0) break;
    end
    check_eq("send_ready", in_ready0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!out_valid0 && i < 100);
    check_eq("result_arrives", out_valid0, 1);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic random_block(input int frames);
    int  n;
    bit  nf, nl;
    bit  done;
    done = 1'b0;
    fork
      begin
        for (int fr = 0; fr < frames; fr++) begin
          n  = $urandom_range(1, 8);
          nf = ($urandom_range(0, 9) == 0);
          nl = ($urandom_range(0, 9) == 0);
          for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) settle();
            send(16'($urandom), 16'($urandom), (k == 0) && !nf, (k == n - 1) && !nl);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
  endtask

  logic [31:0] held;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid0, 0);
    check_eq("rst_out_data", out_data0, 0);
    check_eq("rst_out_count", out_count0, 0);
    check_eq("rst_in_ready", in_ready0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle();

    send(16'h0180, 16'h0200, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("latency_early", out_valid0, 0);
    @(negedge clk);
    check_eq("latency_t2", out_valid0, 1);
    check_eq("single_data", out_data0, 32'h00030000);
    check_eq("single_count", out_count0, 1);
    check_eq("single_sat", out_sat0, 0);
    check_eq("single_sh8", out_data1, 32'h00000300);
    settle();

    for (int k = 0; k < 4; k++) send(16'h0100, 16'h0100, k == 0, k == 3);
    wait_result();
    check_eq("four_data", out_data0, 32'h00040000);
    check_eq("four_count", out_count0, 4);
    settle();

    send(16'hFF00, 16'h0080, 1'b1, 1'b1);
    wait_result();
    check_eq("neg_half", out_data0, 32'hFFFF8000);
    settle();

    for (int s = 1; s >= 0; s--) begin
      sat_en = s[0];
      for (int k = 0; k < 3; k++) send(16'h7FFF, 16'h7FFF, k == 0, k == 2);
      wait_result();
      check_eq("big_data", out_data0, s ? 32'h7FFFFFFF : 32'hBFFD0003);
      check_eq("big_sat", out_sat0, 1);
      check_eq("big_ovf", out_ovf0, 0);
      settle();
    end
    sat_en = 1'b1;

    send(16'h0180, 16'h0100, 1'b1, 1'b1);
    wait_result();
    check_eq("sh8_round_a", out_data1, 32'h00000180);
    check_eq("sh0_a", out_data0, 32'h00018000);
    settle();
    send(16'h0001, 16'h0180, 1'b1, 1'b1);
    wait_result();
    check_eq("sh8_round_up", out_data1, 32'h00000002);
    settle();

    for (int k = 0; k < 20; k++) send(16'h0001, 16'h0001, k == 0, k == 19);
    wait_result();
    check_eq("count20", out_count0, 20);
    check_eq("count_w4_sat", out_count2, 15);
    settle();

    for (int k = 0; k < 520; k++) send(16'h8000, 16'h8000, k == 0, k == 519);
    wait_result();
    check_eq("acc_wrap_ovf", out_ovf0, 1);
    settle();

    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) send(16'h0100, 16'h0200 + 16'(k), k == 0, k == 2);
        for (int k = 0; k < 3; k++) send(16'hFE00, 16'h0100 + 16'(k), k == 0, k == 2);
      end
      begin
        wait_result();
        held = out_data0;
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_in_ready", in_ready0, 0);
          check_eq("stall_hold", out_data0, held);
        end
        settle();
        out_ready = 1'b1;
      end
    join
    drain();

    send(16'h0100, 16'h0300, 1'b1, 1'b0);
    send(16'h0100, 16'h0300, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", out_valid0, 0);
    check_eq("midrst_data", out_data0, 0);
    check_eq("midrst_ovf", out_ovf0, 0);
    check_eq("midrst_count", out_count0, 0);
    settle();
    rst_n = 1'b1;
    settle();
    send(16'h0100, 16'h0200, 1'b1, 1'b0);
    send(16'h0100, 16'h0200, 1'b0, 1'b1);
    wait_result();
    check_eq("postrst_data", out_data0, 32'h00040000);
    check_eq("postrst_count", out_count0, 2);
    settle();

    sat_en = 1'b1;
    random_block(40);
    sat_en = 1'b0;
    random_block(40);

    check_eq("all_retired", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
